machine_timer: RTL and testbench
================================

// Module: machine_timer
// PURPOSE
//  Memory-mapped machine timer (mtime/mtimecmp, CLINT-style). It produces the
//  level time_compare input consumed by interrupt_ctrl (mip[7], mcause 0x80000007).
//  It decodes data-side load/store accesses from the processor's memory stage.
//  It also exports the 64-bit mtime for rdtime/rdtimeh CSR reads.
// PARAMETERS
//  BASE_ADDR  32'h0000_F000  byte base of the 32-byte register window (32-byte aligned)
//  PRESCALE   1              clk cycles per mtime increment; legal range 1..65535
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  resetn        in   1   asynchronous active-low reset
//  sel           in   1   data access strobe, valid for one cycle per access
//  W             in   1   1 = store, 0 = load (sampled with sel)
//  addr          in   32  byte address (sampled with sel)
//  wdata         in   32  store data (sampled with sel & W)
//  rdata         out  32  load data, valid while rvalid=1
//  rvalid        out  1   one-cycle pulse, load data ready
//  addr_err      out  1   one-cycle pulse, misaligned access in window
//  time_compare  out  1   level: registered (mtime >= mtimecmp), unsigned 64-bit
//  mtime         out  64  current counter value
// BEHAVIOUR
//  Reset (async, resetn=0): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, ctrl=32'h1,
//   prescale count=0, rdata=0, rvalid=0, addr_err=0, time_compare=0.
//  Window hit: sel & addr[31:5]==BASE_ADDR[31:5]. If there is no hit, the block does nothing.
//  Offsets: 0x00 mtime[31:0], 0x04 mtime[63:32], 0x08 mtimecmp[31:0],
//   0x0C mtimecmp[63:32], 0x10 ctrl (bit0 EN, bits[31:1] read 0, write ignored).
//   Offsets 0x14-0x1C are unmapped: reads return 0 and writes are ignored, no error.
//  Misaligned hit (addr[1:0]!=0): addr_err=1 next cycle, no write, no rvalid.
//  Load hit: rvalid=1 and rdata=register value as of the sel cycle (pre-update), 1 cycle later.
//   rdata holds its value until the next load. Pipelined back-to-back loads are supported.
//  Store hit: register updates at the same edge. The new value is visible to a load one cycle later.
//  Counting: when EN=1, the prescale count runs 0..PRESCALE-1. At PRESCALE-1 it
//   wraps to 0 and mtime increments by 1. PRESCALE=1 means an increment every cycle.
//   When EN=0, both the prescale count and mtime hold.
//  mtime wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0 with no flag.
//  Carry from bit 31 to bit 32 lands in the same cycle (single 64-bit add).
//  A store to mtime lo/hi in a cycle where an increment would occur: the store wins.
//   The written half takes wdata, the other half holds, and no increment happens that
//   cycle. The prescale count clears to 0.
//  time_compare is registered from the current mtime and mtimecmp registers. It lags
//   their state by 1 cycle and stays asserted until mtimecmp > mtime or mtime wraps.
//  mtimecmp halves update independently; there is no hardware atomicity.
//   Software sequence: hi<=FFFF_FFFF, lo<=new_lo, hi<=new_hi.
//  resetn asserted mid-access: the access is dropped, with no rvalid or addr_err pulse afterwards.
// TESTING
//  1 Reset, then load 0x08 and 0x0C -> rvalid pulses with rdata=FFFF_FFFF for both;
//    time_compare=0 and mtime counts 0,1,2...
//  2 PRESCALE=4, EN=1: observe 12 cycles -> mtime increments exactly 3 times.
//    Store ctrl=0 -> mtime frozen; a load of 0x10 returns 0.
//  3 Store mtime lo=FFFF_FFFF, hi=0 -> the next increment gives hi=1, lo=0.
//    Store hi=lo=FFFF_FFFF -> wraps to 0.
//  4 Store mtimecmp=mtime+5 (hi first): time_compare rises exactly 6 cycles later.
//    Store mtimecmp hi=FFFF_FFFF -> time_compare=0 one cycle after.
//  5 Load 0x02 -> addr_err pulse, no rvalid, no state change.
//    Load 0x18 -> rvalid with rdata=0.
//    Access at BASE_ADDR+0x20 -> no response.
//  6 Store mtime lo on a tick cycle -> lo=wdata exactly, prescale count restarts.
//    Assert resetn=0 during a load -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/machine_timer.sv
// Memory-mapped machine timer: 64-bit mtime/mtimecmp with prescaler, a level
// compare output for the interrupt controller, and a load/store register window.
module machine_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_F000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sel,
    input  logic        W,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        addr_err,
    output logic        time_compare,
    output logic [63:0] mtime
);

    localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_en;
    logic [15:0] r_pre;
    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic        r_addr_err;
    logic        r_time_compare;

    logic        w_hit;
    logic        w_misal;
    logic        w_ld;
    logic        w_st;
    logic [2:0]  w_off;
    logic        w_st_lo;
    logic        w_st_hi;
    logic        w_tick;
    logic [31:0] w_rd_val;
    logic [63:0] w_mtime_nxt;

    assign w_hit   = sel && (addr[31:5] == BASE_ADDR[31:5]);
    assign w_misal = w_hit && (addr[1:0] != 2'b00);
    assign w_off   = addr[4:2];
    assign w_ld    = w_hit && !w_misal && !W;
    assign w_st    = w_hit && !w_misal && W;
    assign w_st_lo = w_st && (w_off == 3'd0);
    assign w_st_hi = w_st && (w_off == 3'd1);
    assign w_tick  = r_en && (r_pre == PS_MAX);

    always_comb begin
        w_rd_val = 32'h0;
        case (w_off)
            3'd0:    w_rd_val = r_mtime[31:0];
            3'd1:    w_rd_val = r_mtime[63:32];
            3'd2:    w_rd_val = r_mtimecmp[31:0];
            3'd3:    w_rd_val = r_mtimecmp[63:32];
            3'd4:    w_rd_val = {31'h0, r_en};
            default: w_rd_val = 32'h0;
        endcase
    end

    // A software write to either mtime half takes priority over the tick.
    always_comb begin
        w_mtime_nxt = r_mtime;
        if (w_st_lo) begin
            w_mtime_nxt[31:0] = wdata;
        end else if (w_st_hi) begin
            w_mtime_nxt[63:32] = wdata;
        end else if (w_tick) begin
            w_mtime_nxt = r_mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mtime        <= 64'h0;
            r_mtimecmp     <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_en           <= 1'b1;
            r_pre          <= 16'h0;
            r_rdata        <= 32'h0;
            r_rvalid       <= 1'b0;
            r_addr_err     <= 1'b0;
            r_time_compare <= 1'b0;
        end else begin
            r_mtime <= w_mtime_nxt;

            if (w_st_lo || w_st_hi || w_tick) begin
                r_pre <= 16'h0;
            end else if (r_en) begin
                r_pre <= r_pre + 16'd1;
            end

            if (w_st && (w_off == 3'd2)) begin
                r_mtimecmp[31:0] <= wdata;
            end
            if (w_st && (w_off == 3'd3)) begin
                r_mtimecmp[63:32] <= wdata;
            end
            if (w_st && (w_off == 3'd4)) begin
                r_en <= wdata[0];
            end

            if (w_ld) begin
                r_rdata <= w_rd_val;
            end
            r_rvalid       <= w_ld;
            r_addr_err     <= w_misal;
            r_time_compare <= (r_mtime >= r_mtimecmp);
        end
    end

    assign mtime        = r_mtime;
    assign rdata        = r_rdata;
    assign rvalid       = r_rvalid;
    assign addr_err     = r_addr_err;
    assign time_compare = r_time_compare;

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer: two instances (PRESCALE 1 and 4) share the bus;
// load data is checked through an expected-value queue.
module tb_machine_timer;

    localparam logic [31:0] B = 32'h0000_F000;

    logic        clk;
    logic        resetn;
    logic        sel;
    logic        W;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        addr_err;
    logic        tc;
    logic [63:0] mtime1;
    logic [31:0] rdata4;
    logic        rvalid4;
    logic        addr_err4;
    logic        tc4;
    logic [63:0] mtime4;

    int          n_asserts = 0;
    int          n_fail    = 0;
    int          edges     = 0;
    int          base      = 0;
    int          m;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd = 32'h0;

    machine_timer #(.BASE_ADDR(B), .PRESCALE(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .sel(sel), .W(W), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rvalid(rvalid), .addr_err(addr_err),
        .time_compare(tc), .mtime(mtime1)
    );

    machine_timer #(.BASE_ADDR(B), .PRESCALE(4)) u_dut4 (
        .clk(clk), .resetn(resetn), .sel(sel), .W(W), .addr(addr), .wdata(wdata),
        .rdata(rdata4), .rvalid(rvalid4), .addr_err(addr_err4),
        .time_compare(tc4), .mtime(mtime4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
        sel   = 1'b1;
        W     = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic idle();
        sel   = 1'b0;
        W     = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
    endtask

    task automatic collect(input string tag);
        logic [31:0] e;
        int k = 0;
        while (!rvalid && k < 4) begin
            cyc();
            k++;
        end
        check({tag, "_rvalid"}, 64'(rvalid), 64'd1);
        if (rvalid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            last_rd = e;
            check({tag, "_rdata"}, 64'(rdata), 64'(e));
        end
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, a, d);
        cyc();
        idle();
    endtask

    task automatic load(input string tag, input logic [31:0] a, input logic [31:0] expv);
        exp_q.push_back(expv);
        drive(1'b0, a, 32'h0);
        cyc();
        idle();
        collect(tag);
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        edges  = 0;

        // reset state
        check("rst_mtime1", mtime1, 64'd0);
        check("rst_mtime4", mtime4, 64'd0);
        check("rst_tc", 64'(tc), 64'd0);
        check("rst_tc4", 64'(tc4), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_addr_err", 64'(addr_err), 64'd0);
        check("rst_rvalid4", 64'(rvalid4), 64'd0);

        // back-to-back loads of mtimecmp halves
        exp_q.push_back(32'hFFFF_FFFF);
        drive(1'b0, B + 32'h08, 32'h0);
        cyc();
        exp_q.push_back(32'hFFFF_FFFF);
        addr = B + 32'h0C;
        collect("cmp_lo");
        cyc();
        idle();
        collect("cmp_hi");
        check("tc_idle", 64'(tc), 64'd0);
        check("count_a", mtime1, 64'(edges));
        cyc();
        check("count_b", mtime1, 64'(edges));
        load("mtime_lo_rd", B, 32'(edges));
        load("ctrl_rst", B + 32'h10, 32'h1);

        // prescale 4: 12 cycles give 3 increments
        m = edges;
        repeat (12) cyc();
        check("ps4_12cyc", mtime4, 64'(m / 4 + 3));

        // disable: the edge that writes ctrl still counts with the old EN
        store(B + 32'h10, 32'h0);
        m = edges;
        check("dis_mtime1", mtime1, 64'(m));
        repeat (3) cyc();
        check("frozen1", mtime1, 64'(m));
        check("frozen4", mtime4, 64'(m / 4));
        load("ctrl_off", B + 32'h10, 32'h0);

        // carry across bit 31 and full wrap
        store(B + 32'h04, 32'h0);
        store(B, 32'hFFFF_FFFF);
        load("lo_wr", B, 32'hFFFF_FFFF);
        load("hi_wr", B + 32'h04, 32'h0);
        store(B + 32'h10, 32'h1);
        check("en_edge", mtime1, 64'h0000_0000_FFFF_FFFF);
        cyc();
        check("carry", mtime1, 64'h0000_0001_0000_0000);
        store(B + 32'h04, 32'hFFFF_FFFF);
        check("hi_store_run", mtime1, 64'hFFFF_FFFF_0000_0000);
        store(B, 32'hFFFF_FFFF);
        check("all_ones", mtime1, 64'hFFFF_FFFF_FFFF_FFFF);
        check("tc_before_eq", 64'(tc), 64'd0);
        cyc();
        check("wrap", mtime1, 64'd0);
        check("tc_at_eq", 64'(tc), 64'd1);
        cyc();
        check("tc_after_wrap", 64'(tc), 64'd0);
        base = edges - 1;

        // compare = mtime + 5
        store(B + 32'h0C, 32'h0);
        m = edges - base;
        store(B + 32'h08, 32'(m + 5));
        repeat (4) cyc();
        check("tc_pre_rise", 64'(tc), 64'd0);
        cyc();
        check("tc_rise", 64'(tc), 64'd1);
        store(B + 32'h0C, 32'hFFFF_FFFF);
        check("tc_hold", 64'(tc), 64'd1);
        cyc();
        check("tc_fall", 64'(tc), 64'd0);
        load("cmp_lo_rd", B + 32'h08, 32'(m + 5));

        // misaligned, unmapped, out of window
        drive(1'b0, B + 32'h02, 32'h0);
        cyc();
        idle();
        check("mis_err", 64'(addr_err), 64'd1);
        check("mis_rvalid", 64'(rvalid), 64'd0);
        check("rdata_hold", 64'(rdata), 64'(last_rd));
        cyc();
        check("mis_err_pulse", 64'(addr_err), 64'd0);
        store(B + 32'h01, 32'h0);
        check("mis_st_err", 64'(addr_err), 64'd1);
        check("mis_st_nowr", mtime1, 64'(edges - base));
        load("unmapped", B + 32'h18, 32'h0);
        store(B + 32'h14, 32'h0);
        check("unm_st_noerr", 64'(addr_err), 64'd0);
        drive(1'b0, B + 32'h20, 32'h0);
        cyc();
        idle();
        check("oow_rvalid", 64'(rvalid), 64'd0);
        check("oow_err", 64'(addr_err), 64'd0);
        store(B + 32'h20, 32'h0);
        check("oow_st_nowr", mtime1, 64'(edges - base));

        // store to mtime on a prescaler tick, then on a non-tick
        store(B, 32'h5000);
        check("lo_set4", 64'(mtime4[31:0]), 64'h5000);
        repeat (3) cyc();
        store(B, 32'h6000);
        check("tick_st4", 64'(mtime4[31:0]), 64'h6000);
        check("tick_st1", mtime1, 64'h0000_0000_0000_6000);
        cyc();
        store(B, 32'h7000);
        repeat (3) cyc();
        check("pre_clr_hold", 64'(mtime4[31:0]), 64'h7000);
        cyc();
        check("pre_clr_inc", 64'(mtime4[31:0]), 64'h7001);

        // reset during a load
        load("cmphi_rd", B + 32'h0C, 32'hFFFF_FFFF);
        drive(1'b0, B + 32'h10, 32'h0);
        #2;
        resetn = 1'b0;
        #1;
        check("mr_mtime1", mtime1, 64'd0);
        check("mr_mtime4", mtime4, 64'd0);
        check("mr_rdata", 64'(rdata), 64'd0);
        check("mr_rvalid", 64'(rvalid), 64'd0);
        check("mr_tc", 64'(tc), 64'd0);
        check("mr_err", 64'(addr_err), 64'd0);
        cyc();
        idle();
        resetn = 1'b1;
        edges  = 0;
        cyc();
        check("mr_dropped", 64'(rvalid), 64'd0);
        check("mr_restart", mtime1, 64'(edges));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
